// File: rtl/sc_match_serializer_pkg.sv
// Shared types for the match serializer: FIFO entry layout, drop counter width, lane index sizing.
// The entry is sized for the largest supported configuration. Smaller builds leave the upper bits at zero.
package sc_pkg;

  localparam int DROP_CNT_W    = 8;
  localparam int SC_LANE_W_MAX = 8;
  localparam int SC_TIME_W_MAX = 32;

  typedef struct packed {
    logic [SC_LANE_W_MAX-1:0] lane;
    logic [SC_TIME_W_MAX-1:0] tstamp;
  } sc_entry_t;

  function automatic int lane_w(input int n_lanes);
    return (n_lanes > 1) ? $clog2(n_lanes) : 1;
  endfunction

endpackage

// File: rtl/sc_match_serializer_if.sv
// Scored-match handshake from the serializer to the score accumulator.
// The master holds every payload field stable while out_valid && !out_ready.
interface sc_match_serializer_if
  import sc_pkg::*;
#(
  parameter int LANE_W = lane_w(37),
  parameter int TIME_W = 16
);
  logic              out_valid;
  logic              out_ready;
  logic [LANE_W-1:0] out_lane;
  logic [TIME_W-1:0] out_dt;
  logic              out_late;

  modport master (output out_valid, out_lane, out_dt, out_late, input out_ready);
  modport slave  (input out_valid, out_lane, out_dt, out_late, output out_ready);
endinterface

// File: rtl/sc_match_serializer_fifo.sv
// Synchronous FIFO built on wrap-around pointers that carry one extra MSB. Reads are zero-latency from the head.
// A push is refused when full and a pop is refused when empty. Full is judged on pre-edge occupancy.
module sc_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_dat,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign pop_dat = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_dat;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + (AW+1)'(1);
        2'b01:   level <= level - (AW+1)'(1);
        default: level <= level;
      endcase
    end
  end
endmodule

// File: rtl/sc_match_serializer.sv
// Turns per-lane match pulses into one scored match per handshake. Latency is 3 cycles from trigger to out_valid when idle.
// Under backpressure the FIFO fills first, then lanes park in pend. A retrigger on a parked lane is counted in drop_cnt.
module sc_match_serializer
  import sc_pkg::*;
#(
  parameter int N_LANES    = 37,
  parameter int TIME_W     = 16,
  parameter int FIFO_DEPTH = 8,
  parameter bit WRAP_EN    = 1'b0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [TIME_W-1:0]           song_time,
  input  logic [N_LANES-1:0]          match_trigger,
  input  logic [N_LANES*TIME_W-1:0]   match_time,
  sc_match_serializer_if.master       out_if,
  output logic [DROP_CNT_W-1:0]       drop_cnt,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);
  localparam int LANE_W = lane_w(N_LANES);
  localparam int SUM_W  = DROP_CNT_W + LANE_W + 1;
  localparam logic [DROP_CNT_W-1:0] DROP_MAX = '1;
  localparam logic [TIME_W-1:0]     HALF     = {1'b1, {(TIME_W-1){1'b0}}};

  logic [N_LANES-1:0] pend, grant_oh, drop_vec;
  logic [TIME_W-1:0]  ptime [N_LANES];
  logic               grant_vld, push, pop, fifo_full, fifo_empty;
  logic [LANE_W-1:0]  grant_idx;
  logic [TIME_W-1:0]  grant_time, head_note, diff, dt_calc;
  logic               late_calc, unused_head;
  logic [LANE_W:0]    n_drop;
  logic [SUM_W-1:0]   drop_sum;
  sc_entry_t          push_entry, head;

  // Ascending scan: the last pending lane seen is the highest index, which wins.
  always_comb begin
    grant_vld  = 1'b0;
    grant_idx  = '0;
    grant_time = '0;
    for (int i = 0; i < N_LANES; i++) begin
      if (pend[i]) begin
        grant_vld  = 1'b1;
        grant_idx  = LANE_W'(i);
        grant_time = ptime[i];
      end
    end
  end

  assign push = grant_vld && !fifo_full;

  always_comb begin
    grant_oh = '0;
    for (int i = 0; i < N_LANES; i++) grant_oh[i] = push && (grant_idx == LANE_W'(i));
  end

  assign drop_vec = match_trigger & pend & ~grant_oh;

  always_comb begin
    n_drop = '0;
    for (int i = 0; i < N_LANES; i++) n_drop = n_drop + (LANE_W+1)'(drop_vec[i]);
  end

  assign drop_sum = SUM_W'(drop_cnt) + SUM_W'(n_drop);

  // A retrigger in the grant cycle replaces the capture instead of being dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend <= '0;
      for (int i = 0; i < N_LANES; i++) ptime[i] <= '0;
      drop_cnt <= '0;
    end else begin
      for (int i = 0; i < N_LANES; i++) begin
        if (match_trigger[i] && (!pend[i] || grant_oh[i])) begin
          pend[i]  <= 1'b1;
          ptime[i] <= match_time[i*TIME_W +: TIME_W];
        end else if (grant_oh[i]) begin
          pend[i] <= 1'b0;
        end
      end
      drop_cnt <= (drop_sum > SUM_W'(DROP_MAX)) ? DROP_MAX : drop_sum[DROP_CNT_W-1:0];
    end
  end

  always_comb begin
    push_entry        = '0;
    push_entry.lane   = SC_LANE_W_MAX'(grant_idx);
    push_entry.tstamp = SC_TIME_W_MAX'(grant_time);
  end

  sc_sync_fifo #(
    .WIDTH ($bits(sc_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .push_dat (push_entry),
    .pop      (pop),
    .pop_dat  (head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .level    (fifo_level)
  );

  assign unused_head = ^{head.lane, head.tstamp};
  assign head_note   = head.tstamp[TIME_W-1:0];
  assign diff        = song_time - head_note;

  always_comb begin
    if (WRAP_EN) begin
      late_calc = (diff <= HALF);
      dt_calc   = late_calc ? diff : (TIME_W'(0) - diff);
    end else begin
      late_calc = (song_time >= head_note);
      dt_calc   = late_calc ? diff : (head_note - song_time);
    end
  end

  assign pop = (!out_if.out_valid || out_if.out_ready) && !fifo_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_if.out_valid <= 1'b0;
      out_if.out_lane  <= '0;
      out_if.out_dt    <= '0;
      out_if.out_late  <= 1'b0;
    end else if (!out_if.out_valid || out_if.out_ready) begin
      out_if.out_valid <= !fifo_empty;
      if (!fifo_empty) begin
        out_if.out_lane <= head.lane[LANE_W-1:0];
        out_if.out_dt   <= dt_calc;
        out_if.out_late <= late_calc;
      end
    end
  end
endmodule

// File: tb/tb_sc_match_serializer.sv
// Directed bench with a scoreboard: expected matches are queued at stimulus time and a negedge monitor pops them on every transfer.
// A second instance built with WRAP_EN=1 covers modular timing.
module tb_sc_match_serializer;
  import sc_pkg::*;

  localparam int NL = 37;
  localparam int TW = 16;

  typedef struct packed {
    logic [5:0]  lane;
    logic [15:0] dt;
    logic        late;
  } exp_t;

  logic           clk, rst_n;
  logic [TW-1:0]  song_time;
  logic [NL-1:0]  trig, trig_w;
  logic [NL*TW-1:0] mtime;
  logic [7:0]     drop_cnt, drop_cnt_w;
  logic [3:0]     fifo_level, fifo_level_w;

  sc_match_serializer_if #(.LANE_W(6), .TIME_W(TW)) oif ();
  sc_match_serializer_if #(.LANE_W(6), .TIME_W(TW)) oif_w ();

  sc_match_serializer #(.N_LANES(NL), .TIME_W(TW), .FIFO_DEPTH(8), .WRAP_EN(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .song_time(song_time), .match_trigger(trig), .match_time(mtime),
    .out_if(oif), .drop_cnt(drop_cnt), .fifo_level(fifo_level)
  );

  sc_match_serializer #(.N_LANES(NL), .TIME_W(TW), .FIFO_DEPTH(8), .WRAP_EN(1'b1)) dut_w (
    .clk(clk), .rst_n(rst_n), .song_time(song_time), .match_trigger(trig_w), .match_time(mtime),
    .out_if(oif_w), .drop_cnt(drop_cnt_w), .fifo_level(fifo_level_w)
  );

  int   n_checks = 0;
  int   n_pass   = 0;
  exp_t exp_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fire(input int lane, input int t);
    trig[lane] = 1'b1;
    mtime[lane*TW +: TW] = TW'(t);
  endtask

  task automatic expect_out(input int lane, input int dt, input bit late);
    exp_t e;
    e.lane = 6'(lane);
    e.dt   = 16'(dt);
    e.late = late;
    exp_q.push_back(e);
  endtask

  task automatic drain(input string name);
    for (int k = 0; k < 200 && exp_q.size() > 0; k++) tick();
    chk(name, exp_q.size(), 0);
  endtask

  // Scoreboard and stall-stability monitor.
  exp_t prev_out;
  bit   stall_prev = 1'b0;
  always @(negedge clk) begin
    exp_t cur, e;
    cur = {oif.out_lane, oif.out_dt, oif.out_late};
    if (!rst_n) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) chk("stall_stable", cur, prev_out);
      if (oif.out_valid && oif.out_ready) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL sb_unexpected: got lane=%0d dt=%0d late=%0d, expected no output",
                   cur.lane, cur.dt, cur.late);
        end else begin
          e = exp_q.pop_front();
          if (cur === e) n_pass++;
          else $display("FAIL sb: got lane=%0d dt=%0d late=%0d, expected lane=%0d dt=%0d late=%0d",
                        cur.lane, cur.dt, cur.late, e.lane, e.dt, e.late);
        end
      end
      stall_prev = oif.out_valid && !oif.out_ready;
      prev_out   = cur;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: run exceeded its time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int got, seen;
    rst_n = 1'b1; trig = '0; trig_w = '0; mtime = '0; song_time = '0;
    oif.out_ready = 1'b0; oif_w.out_ready = 1'b1;
    #2 rst_n = 1'b0;
    #10;
    chk("rst_valid", oif.out_valid, 0);
    chk("rst_lane",  oif.out_lane, 0);
    chk("rst_dt",    oif.out_dt, 0);
    chk("rst_late",  oif.out_late, 0);
    chk("rst_drop",  drop_cnt, 0);
    chk("rst_level", fifo_level, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // Single trigger: visible exactly in cycle 3, for one cycle.
    oif.out_ready = 1'b1; song_time = 16'd1010;
    fire(5, 1000); expect_out(5, 10, 1'b1);
    tick(); trig = '0;
    tick(); chk("single_not_early", oif.out_valid, 0);
    tick(); chk("single_cycle3", oif.out_valid, 1);
    tick(); chk("single_one_cycle", oif.out_valid, 0);
    drain("single_drain");

    // Same-cycle burst comes out highest lane first on consecutive cycles.
    song_time = 16'd510;
    fire(36, 500); fire(20, 520); fire(0, 480);
    expect_out(36, 10, 1'b1); expect_out(20, 10, 1'b0); expect_out(0, 30, 1'b1);
    tick(); trig = '0;
    tick();
    tick(); chk("burst_c3_lane", oif.out_valid ? oif.out_lane : 6'h3f, 36);
    tick(); chk("burst_c4_lane", oif.out_valid ? oif.out_lane : 6'h3f, 20);
    tick(); chk("burst_c5_lane", oif.out_valid ? oif.out_lane : 6'h3f, 0);
    drain("burst_drain");

    // Backpressure: all lanes, then a retrigger on a still-pending lane.
    oif.out_ready = 1'b0; song_time = 16'd2000;
    for (int i = 0; i < NL; i++) fire(i, 1000 + i);
    for (int i = NL - 1; i >= 0; i--) expect_out(i, 1000 - i, 1'b1);
    tick(); trig = '0;
    fire(3, 777);
    tick(); trig = '0;
    repeat (15) tick();
    chk("bp_level_full", fifo_level, 8);
    chk("bp_drop", drop_cnt, 1);
    chk("bp_head_lane", oif.out_lane, 36);
    repeat (5) tick();
    chk("bp_level_hold", fifo_level, 8);
    oif.out_ready = 1'b1;
    drain("bp_drain");
    chk("bp_level_empty", fifo_level, 0);

    // Wrap vs non-wrap on the same note/song pair.
    song_time = 16'd4;
    fire(2, 65530); trig_w[2] = 1'b1; expect_out(2, 65526, 1'b0);
    tick(); trig = '0; trig_w = '0;
    got = 0;
    for (int k = 0; k < 10; k++) begin
      if (oif_w.out_valid) begin got = 1; break; end
      tick();
    end
    chk("wrap_seen", got, 1);
    chk("wrap_lane", oif_w.out_lane, 2);
    chk("wrap_dt",   oif_w.out_dt, 10);
    chk("wrap_late", oif_w.out_late, 1);
    drain("nowrap_drain");

    // Asynchronous reset while 5 entries sit in the FIFO.
    oif.out_ready = 1'b0; song_time = 16'd3000;
    for (int i = 30; i <= 35; i++) fire(i, 2900);
    tick(); trig = '0;
    repeat (10) tick();
    chk("rst_mid_level", fifo_level, 5);
    @(negedge clk); #2 rst_n = 1'b0; #1;
    chk("arst_valid", oif.out_valid, 0);
    chk("arst_lane",  oif.out_lane, 0);
    chk("arst_dt",    oif.out_dt, 0);
    chk("arst_drop",  drop_cnt, 0);
    chk("arst_level", fifo_level, 0);
    tick(); tick();
    rst_n = 1'b1; oif.out_ready = 1'b1;
    seen = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (oif.out_valid) seen++;
    end
    chk("arst_no_stale", seen, 0);

    // Grant and retrigger on lane 7 in the same cycle.
    song_time = 16'd4000;
    fire(7, 3990); expect_out(7, 10, 1'b1);
    tick(); trig = '0;
    fire(7, 3995); expect_out(7, 5, 1'b1);
    tick(); trig = '0;
    drain("collide_drain");
    chk("collide_drop", drop_cnt, 0);
    chk("wrap_inst_drop", drop_cnt_w, 0);
    chk("wrap_inst_level", fifo_level_w, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
